// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing, counter/colour widths and a small range helper
// shared by the VGA scan generator and its pixel divider.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int RGB_W = 3;

  localparam int H_VISIBLE_D = 640;
  localparam int H_FRONT_D   = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BACK_D    = 48;
  localparam int V_VISIBLE_D = 480;
  localparam int V_FRONT_D   = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BACK_D    = 33;

  localparam int H_TOTAL_D = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
  localparam int V_TOTAL_D = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;

  // Inclusive sync windows: hsync low 656..751, vsync low 490..491.
  localparam int H_SYNC_START_D = H_VISIBLE_D + H_FRONT_D;
  localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D - 1;
  localparam int V_SYNC_START_D = V_VISIBLE_D + V_FRONT_D;
  localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D - 1;

  function automatic logic in_span(input logic [CNT_W-1:0] v,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_scan_generator_pixel_tick_gen.sv
// Pixel clock-enable divider: o_tick is high on the last of every CLK_DIV
// cycles (every cycle when CLK_DIV is 1).
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_last;

  assign w_last = (r_div == DIV_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
    end else if (w_last) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_tick = w_last;

endmodule

// File: rtl/vga_scan_generator.sv
// VGA scan generator: row/col scan address, one-tick registered colour/sync
// stage and a vblank_start pulse. Define TEST_PATTERN_EN for the colour-bar input.
module vga_scan_generator
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_D,
  parameter int H_FRONT   = H_SYNC_START_D - H_VISIBLE_D,
  parameter int H_SYNC    = H_SYNC_END_D - H_SYNC_START_D + 1,
  parameter int H_BACK    = H_TOTAL_D - H_SYNC_END_D - 1,
  parameter int V_VISIBLE = V_VISIBLE_D,
  parameter int V_FRONT   = V_SYNC_START_D - V_VISIBLE_D,
  parameter int V_SYNC    = V_SYNC_END_D - V_SYNC_START_D + 1,
  parameter int V_BACK    = V_TOTAL_D - V_SYNC_END_D - 1,
  parameter int CLK_DIV   = 2
) (
  input  logic             clock,
  input  logic             reset,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  input  logic [RGB_W-1:0] rgb_in,
`ifdef TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  output logic [RGB_W-1:0] vga_rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             visible,
  output logic             vblank_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic             w_tick;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_in_view;
  logic [RGB_W-1:0] w_color;

  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic [RGB_W-1:0] r_rgb;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_visible;
  logic             r_vblank_start;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk  (clock),
    .i_rst  (reset),
    .o_tick (w_tick)
  );

  assign w_h_last  = (r_hcount == H_LAST);
  assign w_v_last  = (r_vcount == V_LAST);
  assign w_in_view = (r_hcount < H_VIS) && (r_vcount < V_VIS);

`ifdef TEST_PATTERN_EN
  // 64-pixel vertical bars: colour index is simply col[8:6].
  assign w_color = test_mode ? r_hcount[8:6] : rgb_in;
`else
  assign w_color = rgb_in;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hcount       <= '0;
      r_vcount       <= '0;
      r_rgb          <= '0;
      r_hsync        <= 1'b1;
      r_vsync        <= 1'b1;
      r_visible      <= 1'b0;
      r_vblank_start <= 1'b0;
    end else begin
      // Pulses on the very edge where the counters move to (0, V_VISIBLE).
      r_vblank_start <= w_tick && w_h_last && (r_vcount == V_VIS_LAST);
      if (w_tick) begin
        if (w_h_last) begin
          r_hcount <= '0;
          r_vcount <= w_v_last ? '0 : r_vcount + 1'b1;
        end else begin
          r_hcount <= r_hcount + 1'b1;
        end
        // Output stage describes the address presented during this tick.
        r_visible <= w_in_view;
        r_rgb     <= w_in_view ? w_color : '0;
        r_hsync   <= ~in_span(r_hcount, HS_START, HS_END);
        r_vsync   <= ~in_span(r_vcount, VS_START, VS_END);
      end
    end
  end

  assign row          = r_vcount;
  assign col          = r_hcount;
  assign vga_rgb      = r_rgb;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign visible      = r_visible;
  assign vblank_start = r_vblank_start;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator: cycle-count reference model with per-cycle
// compare, plus literal timing checks; a CLK_DIV=1 instance checks the divider.
module tb_vga_scan_generator;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 8,   VF = 2,  VS = 2,  VB = 3;
  localparam int D  = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rgb_in = 3'b000;
  logic       test_mode = 1'b0;

  logic [9:0] row, col, row1, col1;
  logic [2:0] vga_rgb, vga_rgb1;
  logic       hsync, vsync, visible, vblank_start;
  logic       hsync1, vsync1, visible1, vblank_start1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         model_on = 1'b0;
  bit         mode_dir = 1'b1;
  int         k, p, q, pc, pr;
  logic [2:0] src;
  logic [9:0] e_row, e_col;
  logic [2:0] e_rgb;
  logic       e_hs, e_vs, e_vis, e_vb;

  always #5 clock = ~clock;

  vga_scan_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(D)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .row          (row),
    .col          (col),
    .rgb_in       (rgb_in),
`ifdef TEST_PATTERN_EN
    .test_mode    (test_mode),
`endif
    .vga_rgb      (vga_rgb),
    .hsync        (hsync),
    .vsync        (vsync),
    .visible      (visible),
    .vblank_start (vblank_start)
  );

  vga_scan_generator #(
    .CLK_DIV(1)
  ) dut1 (
    .clock        (clock),
    .reset        (reset),
    .row          (row1),
    .col          (col1),
    .rgb_in       (rgb_in),
`ifdef TEST_PATTERN_EN
    .test_mode    (test_mode),
`endif
    .vga_rgb      (vga_rgb1),
    .hsync        (hsync1),
    .vsync        (vsync1),
    .visible      (visible1),
    .vblank_start (vblank_start1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_pos(input int r, input int c, input string name);
    int n = 0;
    while (!(row == 10'(r) && col == 10'(c)) && n < 40000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40000) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for row %0d col %0d", name, r, c);
    end
  endtask

  // Model: the pixel index is the number of ticks since reset release.
  always @(posedge clock) begin
    if (reset) begin
      model_on = 1'b1;
      k = 0;
      e_row = '0; e_col = '0; e_rgb = '0;
      e_hs = 1'b1; e_vs = 1'b1; e_vis = 1'b0; e_vb = 1'b0;
    end else if (model_on) begin
      k++;
      e_vb = 1'b0;
      if (k % D == 0) begin
        p  = k / D;
        q  = p - 1;
        pc = q % HT;
        pr = (q / HT) % VT;
        src = rgb_in;
`ifdef TEST_PATTERN_EN
        if (test_mode) src = 3'((pc / 64) % 8);
`endif
        e_vis = (pc < HV) && (pr < VV);
        e_rgb = e_vis ? src : 3'b000;
        e_hs  = !(pc >= HV + HF && pc < HV + HF + HS);
        e_vs  = !(pr >= VV + VF && pr < VV + VF + VS);
        e_col = 10'(p % HT);
        e_row = 10'((p / HT) % VT);
        e_vb  = (e_col == 0) && (e_row == 10'(VV));
      end
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      check("row", row, e_row);
      check("col", col, e_col);
      check("vga_rgb", vga_rgb, e_rgb);
      check("hsync", hsync, e_hs);
      check("vsync", vsync, e_vs);
      check("visible", visible, e_vis);
      check("vblank_start", vblank_start, e_vb);
    end
  end

  // Component stand-in: directed colour keyed on the model's current address, else random.
  always @(negedge clock) begin
    if (mode_dir)
      rgb_in = (e_col == 10 && e_row == 5) ? 3'b101 : ((e_col >= HV) ? 3'b111 : 3'b000);
    else
      rgb_in = 3'($urandom_range(0, 7));
  end

  initial begin
    int lows, first_c, first_r, n, vs_low;

    repeat (3) @(negedge clock);
    check("rst_row", row, 0);
    check("rst_col", col, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", vga_rgb, 0);
    check("rst_visible", visible, 0);
    reset = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      check("div2_col", col, i / 2);
      check("div1_col", col1, i);
    end

    // First line: hsync width/position and line wrap.
    lows = 0; first_c = -1;
    for (int i = 0; i < 2000 && row != 10'd1; i++) begin
      @(negedge clock);
      if (hsync == 1'b0) begin
        if (first_c < 0) first_c = col;
        lows++;
      end
    end
    check("hsync_low_clocks", lows, HS * D);
    check("hsync_first_col", first_c, HV + HF + 1);
    check("wrap_row", row, 1);
    check("wrap_col", col, 0);

    // Pixel alignment: colour appears one tick after its address.
    wait_pos(5, 11, "wait_px10");
    check("px10_rgb", vga_rgb, 3'b101);
    check("px10_visible", visible, 1);
    wait_pos(5, 641, "wait_px640");
    check("px640_rgb", vga_rgb, 3'b000);
    check("px640_visible", visible, 0);
    mode_dir = 1'b0;

    // Vertical timing across one full frame.
    n = 0;
    while (vblank_start !== 1'b1 && n < 30000) begin @(negedge clock); n++; end
    check("vb_row", row, VV);
    check("vb_col", col, 0);
    n = 0; vs_low = 0; first_r = -1; first_c = -1;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) check("vb_width", vblank_start, 0);
      if (vsync == 1'b0) begin
        if (first_r < 0) begin first_r = row; first_c = col; end
        vs_low++;
      end
    end while (vblank_start !== 1'b1 && n < 30000);
    check("frame_clocks", n, HT * VT * D);
    check("vsync_low_clocks", vs_low, VS * HT * D);
    check("vsync_first_row", first_r, VV + VF);
    check("vsync_first_col", first_c, 1);

    // Mid-frame reset for one cycle.
    wait_pos(4, 400, "wait_midreset");
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mr_row", row, 0);
    check("mr_col", col, 0);
    check("mr_rgb", vga_rgb, 0);
    check("mr_hsync", hsync, 1);
    check("mr_vsync", vsync, 1);
    check("mr_visible", visible, 0);
    check("mr_vblank", vblank_start, 0);

`ifdef TEST_PATTERN_EN
    test_mode = 1'b1;
    wait_pos(0, 64, "wait_bar63");
    check("bar63", vga_rgb, 3'd0);
    wait_pos(0, 65, "wait_bar64");
    check("bar64", vga_rgb, 3'd1);
    wait_pos(0, 449, "wait_bar448");
    check("bar448", vga_rgb, 3'd7);
    wait_pos(0, 513, "wait_bar512");
    check("bar512", vga_rgb, 3'd0);
    test_mode = 1'b0;
`endif
    repeat (3000) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
